// File: rtl/mux8x1_bl.sv
// -----------------------------------------------------------------------------
// mux8x1_bl
//
// Registered 8-to-1 lane multiplexer. One of eight WIDTH-bit lanes packed
// into I is picked by the 3-bit select s. The result is registered into y
// together with a one-cycle valid qualifier. There is no combinational path
// from s or I to y.
//
// Parameters:
//   WIDTH      bit width of each lane and of y (default 1)
//
// Ports:
//   clk        input   system clock, rising edge
//   rst        input   synchronous reset, active-high
//   in_valid   input   qualifies s and I on this cycle
//   s          input   [2:0] lane select, 0..7
//   I          input   [8*WIDTH-1:0] packed lanes, lane k = I[k*WIDTH +: WIDTH]
//   y          output  [WIDTH-1:0] registered selected lane
//   out_valid  output  high for the cycle after an accepted in_valid
//   y_parity   output  XOR-reduction of the lane written into y
//                      (present only when MUX8X1_PARITY_EN is defined)
//
// Optional feature macro: MUX8X1_PARITY_EN
// -----------------------------------------------------------------------------
module mux8x1_bl #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [2:0]         s,
  input  logic [8*WIDTH-1:0] I,
  output logic [WIDTH-1:0]   y,
`ifdef MUX8X1_PARITY_EN
  output logic               out_valid,
  output logic               y_parity
`else
  output logic               out_valid
`endif
);

  logic [WIDTH-1:0] laneSel;
  logic [WIDTH-1:0] y_d, y_q;
  logic             valid_d, valid_q;

  // Lane decode: compare the select against each constant lane index so
  // every code 0..7 maps to a fixed slice, with no variable part-select.
  always_comb begin
    laneSel = '0;
    for (int k = 0; k < 8; k++) begin
      if (s == 3'(k)) begin
        laneSel = I[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state: an accepted sample loads the selected lane, otherwise y
  // holds. The valid qualifier simply follows in_valid by one cycle.
  always_comb begin
    y_d     = y_q;
    valid_d = in_valid;
    if (in_valid) begin
      y_d = laneSel;
    end
  end

  // Output registers with synchronous reset taking priority over a sample
  // arriving on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign y         = y_q;
  assign out_valid = valid_q;

`ifdef MUX8X1_PARITY_EN
  logic parity_d, parity_q;

  // Parity is computed from the lane being loaded so it is registered on
  // the same edge as y and obeys the same hold rule.
  always_comb begin
    parity_d = parity_q;
    if (in_valid) begin
      parity_d = ^laneSel;
    end
  end

  // Parity register shares the reset and priority rules of y.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign y_parity = parity_q;
`endif

endmodule

// File: tb/tb_mux8x1_bl.sv
// -----------------------------------------------------------------------------
// tb_mux8x1_bl
//
// Self-checking bench for mux8x1_bl. Two instances share clock, reset,
// valid and select: dut1 with WIDTH=1 and dut8 with WIDTH=8. Each driven
// cycle pushes the model's expected outputs to a scoreboard queue, which is
// popped and compared one cycle later. Parity is checked when
// MUX8X1_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_mux8x1_bl;

  typedef struct {
    logic       y1;
    logic [7:0] y8;
    logic       v;
    logic       p;
  } expT;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid;
  logic [2:0]  sel;
  logic [7:0]  in1;
  logic [63:0] in8;
  logic        y1;
  logic [7:0]  y8;
  logic        outValid1;
  logic        outValid8;
  logic        yParity8;

  int checkCount = 0;
  int errorCount = 0;

  expT sb[$];

  // Reference model state
  logic       mY1 = 1'b0;
  logic [7:0] mY8 = 8'h00;
  logic       mP  = 1'b0;

  logic [63:0] rampLanes;
  logic [7:0]  sweepPattern;

  mux8x1_bl #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .s         (sel),
    .I         (in1),
    .y         (y1),
`ifdef MUX8X1_PARITY_EN
    .out_valid (outValid1),
    .y_parity  ()
`else
    .out_valid (outValid1)
`endif
  );

  mux8x1_bl #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .s         (sel),
    .I         (in8),
    .y         (y8),
`ifdef MUX8X1_PARITY_EN
    .out_valid (outValid8),
    .y_parity  (yParity8)
`else
    .out_valid (outValid8)
`endif
  );

`ifndef MUX8X1_PARITY_EN
  assign yParity8 = 1'b0;
`endif

  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout obs=running exp=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, advance the model,
  // push its prediction, then compare just after the rising edge.
  task automatic applyStimulus(input logic r, input logic v, input logic [2:0] s,
                               input logic [7:0] i1, input logic [63:0] i8);
    expT e;
    logic [7:0] lane8;
    @(negedge clk);
    rst     = r;
    inValid = v;
    sel     = s;
    in1     = i1;
    in8     = i8;
    lane8   = 8'(i8 >> (32'(s) * 8));
    if (r) begin
      mY1 = 1'b0;
      mY8 = 8'h00;
      mP  = 1'b0;
    end else if (v) begin
      mY1 = i1[s];
      mY8 = lane8;
      mP  = ^lane8;
    end
    e.y1 = mY1;
    e.y8 = mY8;
    e.v  = v & ~r;
    e.p  = mP;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      checkOutput("y1", 32'(y1), 32'(e.y1));
      checkOutput("y8", 32'(y8), 32'(e.y8));
      checkOutput("valid1", 32'(outValid1), 32'(e.v));
      checkOutput("valid8", 32'(outValid8), 32'(e.v));
`ifdef MUX8X1_PARITY_EN
      checkOutput("parity", 32'(yParity8), 32'(e.p));
`endif
    end
  endtask

  initial begin
    logic [63:0] parLanes;
    rst     = 1'b1;
    inValid = 1'b0;
    sel     = 3'd0;
    in1     = 8'h00;
    in8     = 64'h0;
    for (int k = 0; k < 8; k++) rampLanes[k*8 +: 8] = 8'h10 + 8'(k);
    sweepPattern = 8'b11001100;

    // Reset for two cycles
    applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 64'h0);
    applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 64'h0);
    checkOutput("reset_y", 32'(y1), 32'd0);
    checkOutput("reset_valid", 32'(outValid1), 32'd0);
`ifdef MUX8X1_PARITY_EN
    checkOutput("reset_parity", 32'(yParity8), 32'd0);
`endif

    // Lane sweep: expected 0,0,1,1,0,0,1,1 on WIDTH=1 and 10..17 on WIDTH=8
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b1, 3'(k), sweepPattern, rampLanes);
      checkOutput("sweep_y1", 32'(y1), 32'(((k >> 1) & 1)));
      checkOutput("sweep_y8", 32'(y8), 32'h10 + 32'(k));
      checkOutput("sweep_valid", 32'(outValid1), 32'd1);
    end

    // Reset with a valid sample pending: no capture
    applyStimulus(1'b1, 1'b1, 3'd3, 8'hFF, {8{8'hFF}});
    checkOutput("rstcap_y1", 32'(y1), 32'd0);
    checkOutput("rstcap_y8", 32'(y8), 32'd0);
    checkOutput("rstcap_valid", 32'(outValid1), 32'd0);

    // Hold: capture lane 2, then change I and s with in_valid low
    applyStimulus(1'b0, 1'b1, 3'd2, sweepPattern, rampLanes);
    applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 64'h0);
    checkOutput("hold_y1", 32'(y1), 32'd1);
    checkOutput("hold_y8", 32'(y8), 32'h12);
    checkOutput("hold_valid", 32'(outValid1), 32'd0);

    // Reset mid-stream
    applyStimulus(1'b0, 1'b1, 3'd2, sweepPattern, rampLanes);
    applyStimulus(1'b0, 1'b1, 3'd3, sweepPattern, rampLanes);
    applyStimulus(1'b1, 1'b1, 3'd7, sweepPattern, rampLanes);
    checkOutput("midrst_y1", 32'(y1), 32'd0);
    checkOutput("midrst_valid", 32'(outValid1), 32'd0);
    applyStimulus(1'b0, 1'b1, 3'd6, sweepPattern, rampLanes);
    checkOutput("after_rst_y1", 32'(y1), 32'd1);
    checkOutput("after_rst_y8", 32'(y8), 32'h16);

    // Parity lanes: lane 4 = A7 (odd), lane 5 = 11 (even)
    parLanes = rampLanes;
    parLanes[4*8 +: 8] = 8'hA7;
    parLanes[5*8 +: 8] = 8'h11;
    applyStimulus(1'b0, 1'b1, 3'd4, sweepPattern, parLanes);
    checkOutput("par_lane_A7", 32'(y8), 32'hA7);
`ifdef MUX8X1_PARITY_EN
    checkOutput("par_A7", 32'(yParity8), 32'd1);
`endif
    applyStimulus(1'b0, 1'b1, 3'd5, sweepPattern, parLanes);
    checkOutput("par_lane_11", 32'(y8), 32'h11);
`ifdef MUX8X1_PARITY_EN
    checkOutput("par_11", 32'(yParity8), 32'd0);
`endif

    // Randomised traffic against the model
    for (int n = 0; n < 40; n++) begin
      applyStimulus(($urandom_range(0, 9) == 0), 1'($urandom),
                    3'($urandom_range(0, 7)), 8'($urandom),
                    {$urandom, $urandom});
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
